// File: rtl/stack_mem_unit_pkg.sv
// stack_mem_unit_pkg: shared encodings for the memory-stage stack unit
package stack_mem_unit_pkg;
   localparam int FLAG_W = 3;
   localparam int MC_RE = 6;
   localparam int MC_WE = 5;
   localparam int MC_AS = 3;
   localparam logic [1:0] POP_DATA = 2'b00;
   localparam logic [1:0] POP_PC_L = 2'b10;
   localparam logic [1:0] POP_PC_H = 2'b11;
   typedef enum logic [1:0] {AS_EA = 2'b00, AS_EA_ALT = 2'b01, AS_POP = 2'b10, AS_PUSH = 2'b11} addr_sel_e;
   typedef enum logic [2:0] {
      DS_STD = 3'b000, DS_SRC = 3'b001, DS_FLAGS = 3'b010, DS_PC_CUR_L = 3'b011,
      DS_PC_CUR_H = 3'b100, DS_PC_NXT_L = 3'b101, DS_PC_NXT_H = 3'b110, DS_BAD = 3'b111
   } data_sel_e;
   typedef enum logic {ST_IDLE, ST_WAIT} state_e;
endpackage

// File: rtl/stack_mem_unit_stack_ptr.sv
// stack_ptr: stack pointer register with overflow/underflow compares
module stack_ptr #(
   parameter int ADDR_W = 20,
   parameter logic [ADDR_W-1:0] SP_RESET = '1,
   parameter logic [ADDR_W-1:0] SP_LIMIT = SP_RESET - ADDR_W'(1023)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              dec,
   output logic [ADDR_W-1:0] sp,
   output logic              overflow,
   output logic              underflow
);
   assign overflow = sp < SP_LIMIT;
   assign underflow = sp == SP_RESET;
   // push decrements, pop increments, only on a completed transfer
   always_ff @(posedge clk)
      sp <= rst ? SP_RESET : dec ? sp - ADDR_W'(1) : inc ? sp + ADDR_W'(1) : sp;
endmodule

// File: rtl/stack_mem_unit.sv
// stack_mem_unit: memory-stage executor for loads/stores, push/pop and call/return stack sequences
module stack_mem_unit
   import stack_mem_unit_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 20,
   parameter int PC_W = 2 * DATA_W,
   parameter logic [ADDR_W-1:0] SP_RESET = '1,
   parameter logic [ADDR_W-1:0] SP_LIMIT = SP_RESET - ADDR_W'(1023)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [6:0]        mem_ctrl,
   input  logic              sp_wr,
   input  logic              flags_wb,
   input  logic [1:0]        pop_l_h,
   input  logic [ADDR_W-1:0] alu_result,
   input  logic [DATA_W-1:0] src_data,
   input  logic [FLAG_W-1:0] flags_in,
   input  logic [PC_W-1:0]   pc_cur,
   input  logic [PC_W-1:0]   pc_next,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   output logic              mem_we,
   output logic              stall,
   output logic [DATA_W-1:0] load_data,
   output logic              load_valid,
   output logic [PC_W-1:0]   ret_pc,
   output logic              ret_pc_valid,
   output logic [FLAG_W-1:0] flags_restore,
   output logic              flags_restore_valid,
   output logic [ADDR_W-1:0] sp,
   output logic              stack_fault
);
   state_e state, state_nx;
   addr_sel_e asel;
   data_sel_e dsel;
   logic rd_i, wr_i, is_push, is_pop, ovf, unf, d_re, d_we, d_bad;
   logic [ADDR_W-1:0] d_addr, h_addr;
   logic [DATA_W-1:0] d_wdata, h_wdata, rdata, low_half;
   logic h_re, h_we, h_sp_wr, h_flags_wb, c_sp_wr, c_flags_wb;
   logic [1:0] h_pop_l_h, c_pop_l_h;
   logic done, rd_done, r_flag, r_lo, r_hi, r_data, half_full, overflow, underflow;

   stack_ptr #(.ADDR_W(ADDR_W), .SP_RESET(SP_RESET), .SP_LIMIT(SP_LIMIT)) u_sp (
      .clk(clk), .rst(rst),
      .inc(done && mem_re && c_sp_wr), .dec(done && mem_we && c_sp_wr),
      .sp(sp), .overflow(overflow), .underflow(underflow)
   );

   // decode the incoming control word into a candidate request and its fault conditions
   always_comb begin
      rd_i = mem_ctrl[MC_RE];
      wr_i = mem_ctrl[MC_WE];
      asel = addr_sel_e'(mem_ctrl[MC_AS +: 2]);
      dsel = data_sel_e'(mem_ctrl[2:0]);
      is_push = wr_i && !rd_i && asel == AS_PUSH;
      is_pop = rd_i && !wr_i && asel == AS_POP;
      ovf = is_push && overflow;
      unf = is_pop && underflow;
      d_addr = asel == AS_POP ? sp + ADDR_W'(1) : asel == AS_PUSH ? sp : alu_result;
      d_re = rd_i && !wr_i && !unf;
      d_we = wr_i && !rd_i && !ovf;
      d_bad = (rd_i && wr_i) || ovf || unf || (wr_i && !rd_i && dsel == DS_BAD);
   end

   // write-data source select
   always_comb begin
      d_wdata = '0;
      case (dsel)
         DS_STD, DS_SRC: d_wdata = src_data;
         DS_FLAGS:       d_wdata = DATA_W'(flags_in);
         DS_PC_CUR_L:    d_wdata = pc_cur[DATA_W-1:0];
         DS_PC_CUR_H:    d_wdata = pc_cur[PC_W-1:DATA_W];
         DS_PC_NXT_L:    d_wdata = pc_next[DATA_W-1:0];
         DS_PC_NXT_H:    d_wdata = pc_next[PC_W-1:DATA_W];
         default:        d_wdata = '0;
      endcase
   end

   // state register
   always_ff @(posedge clk)
      state <= rst ? ST_IDLE : state_nx;

   // stay in WAIT exactly while the active request is unanswered
   always_comb
      state_nx = stall ? ST_WAIT : ST_IDLE;

   // drive the live request in IDLE, the captured one in WAIT; reset drops it at once
   always_comb begin
      mem_re = !rst && (state == ST_WAIT ? h_re : d_re);
      mem_we = !rst && (state == ST_WAIT ? h_we : d_we);
      mem_addr = state == ST_WAIT ? h_addr : d_addr;
      mem_wdata = state == ST_WAIT ? h_wdata : d_wdata;
      c_sp_wr = state == ST_WAIT ? h_sp_wr : sp_wr;
      c_flags_wb = state == ST_WAIT ? h_flags_wb : flags_wb;
      c_pop_l_h = state == ST_WAIT ? h_pop_l_h : pop_l_h;
      stall = (mem_re || mem_we) && !mem_ready;
      done = (mem_re || mem_we) && mem_ready;
      rd_done = (mem_re && mem_ready) || (state == ST_IDLE && unf && !rst);
      rdata = mem_re ? mem_rdata : '0;
      r_flag = c_flags_wb;
      r_lo = !c_flags_wb && c_pop_l_h == POP_PC_L;
      r_hi = !c_flags_wb && c_pop_l_h == POP_PC_H;
      r_data = !r_flag && !r_lo && !r_hi;
   end

   // capture the request while idle so it stays stable through wait states
   always_ff @(posedge clk)
      if (rst) begin
         {h_re, h_we, h_sp_wr, h_flags_wb} <= '0;
         h_pop_l_h <= POP_DATA;
         h_addr <= '0;
         h_wdata <= '0;
      end else if (state == ST_IDLE) begin
         {h_re, h_we, h_sp_wr, h_flags_wb} <= {d_re, d_we, sp_wr, flags_wb};
         h_pop_l_h <= pop_l_h;
         h_addr <= d_addr;
         h_wdata <= d_wdata;
      end

   // route completed reads to load, flag or return-PC results and track sticky faults
   always_ff @(posedge clk)
      if (rst) begin
         {load_valid, ret_pc_valid, flags_restore_valid, half_full, stack_fault} <= '0;
         load_data <= '0;
         ret_pc <= '0;
         flags_restore <= '0;
         low_half <= '0;
      end else begin
         load_valid <= rd_done && r_data;
         ret_pc_valid <= rd_done && r_hi && half_full;
         flags_restore_valid <= rd_done && r_flag;
         if (rd_done && r_data) load_data <= rdata;
         if (rd_done && r_flag) flags_restore <= rdata[FLAG_W-1:0];
         if (rd_done && r_lo) begin
            low_half <= rdata;
            half_full <= 1'b1;
         end
         if (rd_done && r_hi && half_full) begin
            ret_pc <= {rdata, low_half};
            half_full <= 1'b0;
         end
         stack_fault <= stack_fault || (state == ST_IDLE && d_bad) || (rd_done && r_hi && !half_full);
      end
endmodule

// File: tb/tb_stack_mem_unit.sv
// tb_stack_mem_unit: directed and random checks of stack_mem_unit against a stack/memory model
module tb_stack_mem_unit;
   localparam logic [19:0] SP_RESET = 20'hFFFFF;
   localparam logic [19:0] SP_LIMIT = 20'hFFC00;

   logic clk = 0, rst = 1;
   logic [6:0] mem_ctrl = 0;
   logic sp_wr = 0, flags_wb = 0, mem_ready = 1;
   logic [1:0] pop_l_h = 0;
   logic [19:0] alu_result = 0;
   logic [15:0] src_data = 0, mem_rdata;
   logic [2:0] flags_in = 0;
   logic [31:0] pc_cur = 0, pc_next = 0;
   logic [19:0] mem_addr, sp;
   logic [15:0] mem_wdata, load_data;
   logic mem_re, mem_we, stall, load_valid, ret_pc_valid, flags_restore_valid, stack_fault;
   logic [31:0] ret_pc;
   logic [2:0] flags_restore;

   logic [15:0] bmem [0:4095];
   logic [15:0] ref_mem [int];
   logic [19:0] sp_m;
   logic fault_m, half_m;
   logic [15:0] low_m;
   int n_chk = 0, n_fail = 0;

   stack_mem_unit dut (
      .clk(clk), .rst(rst), .mem_ctrl(mem_ctrl), .sp_wr(sp_wr), .flags_wb(flags_wb),
      .pop_l_h(pop_l_h), .alu_result(alu_result), .src_data(src_data), .flags_in(flags_in),
      .pc_cur(pc_cur), .pc_next(pc_next), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
      .stall(stall), .load_data(load_data), .load_valid(load_valid), .ret_pc(ret_pc),
      .ret_pc_valid(ret_pc_valid), .flags_restore(flags_restore),
      .flags_restore_valid(flags_restore_valid), .sp(sp), .stack_fault(stack_fault)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem_re ? bmem[mem_addr[11:0]] : 16'h0;
   always @(posedge clk) if (mem_we && mem_ready) bmem[mem_addr[11:0]] <= mem_wdata;

   function automatic logic [15:0] rd_ref(input logic [19:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      mem_ctrl = 0; sp_wr = 0; flags_wb = 0; pop_l_h = 0; alu_result = 0;
   endtask

   task automatic do_reset();
      rst = 1; idle_inputs(); mem_ready = 1;
      @(posedge clk); #1;
      rst = 0;
      sp_m = SP_RESET; fault_m = 0; half_m = 0;
      chk("rst_sp", sp, sp_m);
      chk("rst_fault", stack_fault, fault_m);
      chk("rst_pulses", {load_valid, ret_pc_valid, flags_restore_valid, mem_re, mem_we, stall}, 6'b0);
   endtask

   // one transfer: nw ready-low cycles, then completion; samples request and leaves inputs idle
   task automatic op(input logic [6:0] c, input logic spw, input logic fwb, input logic [1:0] plh,
                     input logic [19:0] alu, input int nw, input logic exp_req,
                     input logic [19:0] exp_addr, input logic [15:0] exp_wdata, output int stalls);
      mem_ctrl = c; sp_wr = spw; flags_wb = fwb; pop_l_h = plh; alu_result = alu; stalls = 0;
      for (int i = 0; i < nw && exp_req; i++) begin
         mem_ready = 0; #1;
         stalls += int'(stall);
         chk("wait_addr", mem_addr, exp_addr);
         @(posedge clk); #1;
      end
      mem_ready = 1; #1;
      chk("strobes", {mem_re, mem_we}, {exp_req & c[6], exp_req & c[5]});
      chk("stall_ready", stall, 1'b0);
      if (exp_req) chk("addr", mem_addr, exp_addr);
      if (exp_req && c[5]) chk("wdata", mem_wdata, exp_wdata);
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic chk_pulses(input logic lv, input logic rv, input logic fv,
                             input logic [15:0] d, input logic [31:0] rp);
      chk("pulses", {load_valid, ret_pc_valid, flags_restore_valid}, {lv, rv, fv});
      if (lv) chk("load_data", load_data, d);
      if (rv) chk("ret_pc", ret_pc, rp);
      if (fv) chk("flags_restore", flags_restore, d[2:0]);
   endtask

   task automatic do_push(input logic [2:0] ds, input logic [15:0] d, input int nw);
      logic ov;
      int st;
      ov = sp_m < SP_LIMIT;
      op({4'b0111, ds}, 1'b1, 1'b0, 2'b00, 20'h0, nw, !ov, sp_m, d, st);
      if (ds == 3'b111) fault_m = 1;
      if (ov) fault_m = 1;
      else begin
         ref_mem[int'(sp_m)] = d;
         sp_m = sp_m - 20'd1;
         chk("push_stalls", st, nw);
      end
      chk("push_sp", sp, sp_m);
      chk("push_fault", stack_fault, fault_m);
   endtask

   task automatic do_pop(input logic fwb, input logic [1:0] plh, input int nw);
      logic un, lv, rv;
      logic [15:0] d;
      logic [31:0] rp;
      int st;
      un = sp_m == SP_RESET;
      op(7'b1010000, 1'b1, fwb, plh, 20'h0, nw, !un, sp_m + 20'd1, 16'h0, st);
      if (un) begin
         fault_m = 1;
         d = 0;
      end else begin
         sp_m = sp_m + 20'd1;
         d = rd_ref(sp_m);
         chk("pop_stalls", st, nw);
      end
      lv = 0; rv = 0; rp = 0;
      if (fwb) ;
      else if (plh == 2'b10) begin low_m = d; half_m = 1; end
      else if (plh == 2'b11) begin
         if (half_m) begin rv = 1; rp = {d, low_m}; half_m = 0; end
         else fault_m = 1;
      end else lv = 1;
      chk_pulses(lv, rv, fwb, d, rp);
      chk("pop_sp", sp, sp_m);
      chk("pop_fault", stack_fault, fault_m);
      @(posedge clk); #1;
      chk("pulse_clear", {load_valid, ret_pc_valid, flags_restore_valid}, 3'b000);
   endtask

   task automatic do_st(input logic [19:0] a, input logic [15:0] d, input int nw, input logic alt);
      int st;
      op({3'b010, alt, 3'b000}, 1'b0, 1'b0, 2'b00, a, nw, 1'b1, a, d, st);
      ref_mem[int'(a)] = d;
      chk("st_stalls", st, nw);
      chk("st_sp", sp, sp_m);
   endtask

   task automatic do_ld(input logic [19:0] a, input int nw, input logic alt);
      int st;
      op({3'b100, alt, 3'b000}, 1'b0, 1'b0, 2'b00, a, nw, 1'b1, a, 16'h0, st);
      chk("ld_stalls", st, nw);
      chk_pulses(1'b1, 1'b0, 1'b0, rd_ref(a), 32'h0);
      chk("ld_sp", sp, sp_m);
   endtask

   initial begin
      int nw, st;
      logic [19:0] a;
      for (int i = 0; i < 4096; i++) bmem[i] = 16'h0;
      @(posedge clk); #1;
      do_reset();
      chk("rst_data", {load_data, ret_pc, flags_restore}, 51'h0);

      src_data = 16'hBEEF;
      do_push(3'b001, 16'hBEEF, 0);

      do_reset();
      pc_next = 32'h0001_2345;
      do_push(3'b110, 16'h0001, 0);
      do_push(3'b101, 16'h2345, 0);
      chk("call_mem_hi", bmem[12'hFFF], 16'h0001);
      chk("call_mem_lo", bmem[12'hFFE], 16'h2345);
      do_pop(1'b0, 2'b10, 0);
      do_pop(1'b0, 2'b11, 3);

      do_reset();
      do_pop(1'b0, 2'b00, 0);
      do_reset();

      pc_cur = 32'hABCD_1234; flags_in = 3'b101;
      do_push(3'b100, 16'hABCD, 1);
      do_push(3'b011, 16'h1234, 0);
      do_push(3'b010, 16'h0005, 2);
      do_pop(1'b1, 2'b00, 0);
      do_pop(1'b0, 2'b10, 1);
      do_pop(1'b0, 2'b11, 0);

      do_reset();
      src_data = 16'h1111; do_push(3'b001, 16'h1111, 0);
      src_data = 16'h2222; do_push(3'b001, 16'h2222, 0);
      do_pop(1'b0, 2'b10, 0);
      mem_ctrl = 7'b1010000; sp_wr = 1; pop_l_h = 2'b11; mem_ready = 0; #1;
      chk("rw_stall", stall, 1'b1);
      @(posedge clk); #1;
      chk("rw_wait_re", {mem_re, stall}, 2'b11);
      rst = 1; #1;
      chk("rw_drop", {mem_re, stall}, 2'b00);
      @(posedge clk); #1;
      rst = 0; idle_inputs(); mem_ready = 1;
      sp_m = SP_RESET; fault_m = 0; half_m = 0;
      chk("rw_sp", sp, sp_m);
      chk("rw_fault", stack_fault, fault_m);
      src_data = 16'h3333; do_push(3'b001, 16'h3333, 0);
      do_pop(1'b0, 2'b11, 0);

      do_reset();
      op(7'b1100000, 1'b0, 1'b0, 2'b00, 20'h5, 0, 1'b0, 20'h0, 16'h0, st);
      fault_m = 1;
      chk("both_fault", stack_fault, fault_m);
      chk("both_sp", sp, sp_m);

      do_reset();
      src_data = 16'hFFFF;
      do_push(3'b111, 16'h0000, 0);

      do_reset();
      for (int i = 0; i < 1024; i++) begin
         src_data = 16'(i);
         do_push(3'b001, 16'(i), 0);
      end
      src_data = 16'hDEAD;
      do_push(3'b001, 16'hDEAD, 0);
      do_pop(1'b0, 2'b00, 0);

      do_reset();
      for (int k = 0; k < 150; k++) begin
         nw = $urandom_range(0, 2);
         a = 20'($urandom_range(0, 1023));
         case ($urandom_range(0, 3))
            0: begin src_data = 16'($urandom); do_push(3'b001, src_data, nw); end
            1: do_pop(1'b0, 2'b00, nw);
            2: begin src_data = 16'($urandom); do_st(a, src_data, nw, 1'($urandom_range(0, 1))); end
            default: do_ld(a, nw, 1'($urandom_range(0, 1)));
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
